// File: rtl/constraint_eval_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : constraint_eval_pipe
// Function : three-stage evaluator of a programmable single-term constraint
//            table, reporting joint satisfaction, the lowest failing index and
//            saturating accept/total counters.
// Revision : 1.0 - initial release
// ============================================================================
module constraint_eval_pipe #(
    parameter int  NUM_VARS = 20,
    parameter int  VAR_W    = 64,
    parameter int  NUM_CONS = 20,
    parameter int  CNT_W    = 32,
    localparam int SW       = (NUM_VARS > 1) ? $clog2(NUM_VARS) : 1,
    localparam int CW       = (NUM_CONS > 1) ? $clog2(NUM_CONS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_we,
    input  logic [CW-1:0]             cfg_idx,
    input  logic [3:0]                cfg_op,
    input  logic [SW-1:0]             cfg_a,
    input  logic [SW-1:0]             cfg_b,
    input  logic [VAR_W-1:0]          cfg_imm,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_VARS*VAR_W-1:0] in_vars,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_sat,
    output logic [CW-1:0]             out_fail_idx,
    input  logic                      cnt_clr,
    output logic [CNT_W-1:0]          sat_cnt,
    output logic [CNT_W-1:0]          total_cnt
);

    localparam logic [3:0] OP_NOP    = 4'd0;
    localparam logic [3:0] OP_XORI   = 4'd1;
    localparam logic [3:0] OP_ADDI   = 4'd2;
    localparam logic [3:0] OP_ORI    = 4'd3;
    localparam logic [3:0] OP_SUBI   = 4'd4;
    localparam logic [3:0] OP_MULI   = 4'd5;
    localparam logic [3:0] OP_XOR    = 4'd6;
    localparam logic [3:0] OP_ADD    = 4'd7;
    localparam logic [3:0] OP_MUL    = 4'd8;
    localparam logic [3:0] OP_LAND   = 4'd9;
    localparam logic [3:0] OP_IMPL   = 4'd10;
    localparam logic [3:0] OP_XNORI  = 4'd11;
    localparam logic [3:0] OP_SHRI   = 4'd12;
    localparam logic [3:0] OP_SHLXOR = 4'd13;
    localparam logic [3:0] OP_ISZERO = 4'd14;
    localparam logic [3:0] OP_NMUL   = 4'd15;

    // Shift amount is always the low six immediate bits; SV shifts by >= VAR_W yield 0.
    function automatic logic eval_con(input logic [3:0]       op,
                                      input logic [VAR_W-1:0] a,
                                      input logic [VAR_W-1:0] b,
                                      input logic [VAR_W-1:0] imm);
        logic [VAR_W-1:0] r;
        logic [5:0]       sh;
        sh = 6'(imm);
        r  = '0;
        case (op)
            OP_NOP:    r = VAR_W'(1'b1);
            OP_XORI:   r = a ^ imm;
            OP_ADDI:   r = a + imm;
            OP_ORI:    r = a | imm;
            OP_SUBI:   r = a - imm;
            OP_MULI:   r = a * imm;
            OP_XOR:    r = a ^ b;
            OP_ADD:    r = a + b;
            OP_MUL:    r = a * b;
            OP_LAND:   r = VAR_W'((a != '0) && (b != '0));
            OP_IMPL:   r = VAR_W'((a == '0) || (b != '0));
            OP_XNORI:  r = (~a) ^ imm;
            OP_SHRI:   r = a >> sh;
            OP_SHLXOR: r = (a << sh) ^ b;
            OP_ISZERO: r = VAR_W'(a == '0);
            OP_NMUL:   r = ~(a * b);
            default:   r = '0;
        endcase
        return |r;
    endfunction

    logic [3:0]          tab_op_q  [NUM_CONS];
    logic [SW-1:0]       tab_a_q   [NUM_CONS];
    logic [SW-1:0]       tab_b_q   [NUM_CONS];
    logic [VAR_W-1:0]    tab_imm_q [NUM_CONS];

    logic                      adv;
    logic                      s1_valid_q;
    logic [NUM_VARS*VAR_W-1:0] s1_vars_q;
    logic [VAR_W-1:0]          s1_var [NUM_VARS];
    logic                      s2_valid_q;
    logic [NUM_CONS-1:0]       s2_bits_q;
    logic [NUM_CONS-1:0]       con_bits_d;
    logic                      out_valid_q;
    logic                      out_sat_q;
    logic                      sat_d;
    logic [CW-1:0]             out_fail_idx_q;
    logic [CW-1:0]             fail_idx_d;
    logic [CNT_W-1:0]          sat_cnt_q;
    logic [CNT_W-1:0]          sat_cnt_d;
    logic [CNT_W-1:0]          total_cnt_q;
    logic [CNT_W-1:0]          total_cnt_d;

    // One global advance keeps the three slots in lockstep, so stalls never reorder.
    assign adv          = !out_valid_q || out_ready;
    assign in_ready     = adv;
    assign out_valid    = out_valid_q;
    assign out_sat      = out_sat_q;
    assign out_fail_idx = out_fail_idx_q;
    assign sat_cnt      = sat_cnt_q;
    assign total_cnt    = total_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CONS; i++) begin
                tab_op_q[i]  <= OP_NOP;
                tab_a_q[i]   <= '0;
                tab_b_q[i]   <= '0;
                tab_imm_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CONS; i++) begin
                if (cfg_we && (cfg_idx == CW'(i))) begin
                    tab_op_q[i]  <= cfg_op;
                    tab_a_q[i]   <= cfg_a;
                    tab_b_q[i]   <= cfg_b;
                    tab_imm_q[i] <= cfg_imm;
                end
            end
        end
    end

    generate
        for (genvar k = 0; k < NUM_VARS; k++) begin : g_unpack
            assign s1_var[k] = s1_vars_q[k*VAR_W +: VAR_W];
        end

        for (genvar i = 0; i < NUM_CONS; i++) begin : g_cons
            logic [VAR_W-1:0] opa;
            logic [VAR_W-1:0] opb;

            // Selects with no matching variable fall through to a zero operand.
            always_comb begin
                opa = '0;
                opb = '0;
                for (int k = 0; k < NUM_VARS; k++) begin
                    if (tab_a_q[i] == SW'(k)) opa = s1_var[k];
                    if (tab_b_q[i] == SW'(k)) opb = s1_var[k];
                end
            end

            assign con_bits_d[i] = eval_con(tab_op_q[i], opa, opb, tab_imm_q[i]);
        end
    endgenerate

    always_comb begin
        sat_d      = &s2_bits_q;
        fail_idx_d = '0;
        for (int i = NUM_CONS - 1; i >= 0; i--) begin
            if (!s2_bits_q[i]) fail_idx_d = CW'(i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q     <= 1'b0;
            s1_vars_q      <= '0;
            s2_valid_q     <= 1'b0;
            s2_bits_q      <= '0;
            out_valid_q    <= 1'b0;
            out_sat_q      <= 1'b0;
            out_fail_idx_q <= '0;
        end else if (adv) begin
            s1_valid_q     <= in_valid;
            if (in_valid) s1_vars_q <= in_vars;
            s2_valid_q     <= s1_valid_q;
            s2_bits_q      <= con_bits_d;
            out_valid_q    <= s2_valid_q;
            out_sat_q      <= sat_d;
            out_fail_idx_q <= fail_idx_d;
        end
    end

    always_comb begin
        sat_cnt_d   = sat_cnt_q;
        total_cnt_d = total_cnt_q;
        if (cnt_clr) begin
            sat_cnt_d   = '0;
            total_cnt_d = '0;
        end else if (out_valid_q && out_ready) begin
            if (total_cnt_q != '1)              total_cnt_d = total_cnt_q + CNT_W'(1);
            if (out_sat_q && (sat_cnt_q != '1)) sat_cnt_d   = sat_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_cnt_q   <= '0;
            total_cnt_q <= '0;
        end else begin
            sat_cnt_q   <= sat_cnt_d;
            total_cnt_q <= total_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_constraint_eval_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_constraint_eval_pipe
// Function : directed self-checking bench for constraint_eval_pipe.
// Revision : 1.0 - initial release
// ============================================================================
module tb_constraint_eval_pipe;

    localparam int NV   = 20;
    localparam int VW   = 64;
    localparam int NC   = 20;
    localparam int CNTW = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_we;
    logic [4:0]        cfg_idx;
    logic [3:0]        cfg_op;
    logic [4:0]        cfg_a;
    logic [4:0]        cfg_b;
    logic [VW-1:0]     cfg_imm;
    logic              in_valid;
    logic              in_ready;
    logic [NV*VW-1:0]  in_vars;
    logic              out_valid;
    logic              out_ready;
    logic              out_sat;
    logic [4:0]        out_fail_idx;
    logic              cnt_clr;
    logic [CNTW-1:0]   sat_cnt;
    logic [CNTW-1:0]   total_cnt;

    int                n_checks = 0;
    int                n_fail   = 0;
    logic [NV*VW-1:0]  cand;

    constraint_eval_pipe #(
        .NUM_VARS (NV),
        .VAR_W    (VW),
        .NUM_CONS (NC),
        .CNT_W    (CNTW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_we       (cfg_we),
        .cfg_idx      (cfg_idx),
        .cfg_op       (cfg_op),
        .cfg_a        (cfg_a),
        .cfg_b        (cfg_b),
        .cfg_imm      (cfg_imm),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_vars      (in_vars),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sat      (out_sat),
        .out_fail_idx (out_fail_idx),
        .cnt_clr      (cnt_clr),
        .sat_cnt      (sat_cnt),
        .total_cnt    (total_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [4:0] idx, input logic [3:0] op,
                             input logic [4:0] a, input logic [4:0] b, input logic [63:0] imm);
        cfg_we  = 1'b1;
        cfg_idx = idx;
        cfg_op  = op;
        cfg_a   = a;
        cfg_b   = b;
        cfg_imm = imm;
        tick();
        cfg_we  = 1'b0;
    endtask

    // Single candidate through an idle pipeline with out_ready=1; result sampled at N+2.
    task automatic run_one(input logic [NV*VW-1:0] v, output logic sat, output logic [4:0] idx);
        check("run_in_ready", in_ready, 1);
        in_vars  = v;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check("run_lat_n1", out_valid, 0);
        tick();
        check("run_lat_n2", out_valid, 1);
        sat = out_sat;
        idx = out_fail_idx;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!out_valid && n < 10) begin
            tick();
            n++;
        end
        if (!out_valid) check({tag, "_timeout"}, 0, 1);
    endtask

    // Entry 7 holds the opcode under test; A=var1, B=var2 unless the selects say otherwise.
    task automatic do_op(input string tag, input logic [3:0] op, input logic [4:0] a, input logic [4:0] b,
                         input logic [63:0] imm, input logic [63:0] va, input logic [63:0] vb,
                         input logic exp_bit);
        logic       s;
        logic [4:0] idx;
        cfg_write(5'd7, op, a, b, imm);
        cand = '0;
        cand[1*VW +: VW] = va;
        cand[2*VW +: VW] = vb;
        run_one(cand, s, idx);
        check({tag, "_sat"}, s, exp_bit);
        check({tag, "_idx"}, idx, exp_bit ? 64'd0 : 64'd7);
    endtask

    function automatic logic [NV*VW-1:0] bp_cand(input int k);
        logic [NV*VW-1:0] v;
        for (int j = 0; j < NV; j++) v[j*VW +: VW] = (j == 10 + k) ? 64'd0 : 64'd1;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       s;
        logic [4:0] idx;
        int         nacc;
        int         ngot;
        int         nseen;
        logic       acc;

        rst = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_op = '0; cfg_a = '0; cfg_b = '0; cfg_imm = '0;
        in_valid = 1'b0; in_vars = '0; out_ready = 1'b1; cnt_clr = 1'b0; cand = '0;
        repeat (2) tick();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sat", out_sat, 0);
        check("rst_fail_idx", out_fail_idx, 0);
        check("rst_sat_cnt", sat_cnt, 0);
        check("rst_total_cnt", total_cnt, 0);
        rst = 1'b0;
        tick();

        // NOP table: any candidate satisfies.
        for (int j = 0; j < NV; j++) cand[j*VW +: VW] = 64'hDEAD_BEEF_0000_0000 | 64'(j);
        run_one(cand, s, idx);
        check("nop_sat", s, 1);
        check("nop_idx", idx, 0);
        tick();
        check("nop_total", total_cnt, 1);
        check("nop_satcnt", sat_cnt, 1);

        // Out-of-range index write must be dropped.
        cfg_write(5'd20, 4'd1, 5'd25, 5'd0, 64'd0);
        run_one(cand, s, idx);
        check("oor_write_sat", s, 1);

        cfg_write(5'd3, 4'd1, 5'd4, 5'd0, 64'h31);
        cand = '0; cand[4*VW +: VW] = 64'h31;
        run_one(cand, s, idx);
        check("xori_eq_sat", s, 0);
        check("xori_eq_idx", idx, 3);
        cand[4*VW +: VW] = 64'h30;
        run_one(cand, s, idx);
        check("xori_ne_sat", s, 1);
        check("xori_ne_idx", idx, 0);

        cfg_write(5'd0, 4'd9, 5'd19, 5'd16, 64'd0);
        cfg_write(5'd5, 4'd14, 5'd5, 5'd0, 64'd0);
        cand = '0; cand[16*VW +: VW] = 64'd5;
        run_one(cand, s, idx);
        check("prio_sat", s, 0);
        check("prio_idx0", idx, 0);
        cand[19*VW +: VW] = 64'd1; cand[5*VW +: VW] = 64'd7;
        run_one(cand, s, idx);
        check("prio_idx5", idx, 5);
        tick();
        check("cnt_total6", total_cnt, 6);
        check("cnt_sat3", sat_cnt, 3);

        cfg_write(5'd0, 4'd0, 5'd0, 5'd0, 64'd0);
        cfg_write(5'd5, 4'd0, 5'd0, 5'd0, 64'd0);
        do_op("op0_nop",    4'd0,  5'd1,  5'd2,  64'd0,  64'd0, 64'd0, 1'b1);
        do_op("op2_wrap",   4'd2,  5'd1,  5'd2,  64'd1,  '1, 64'd0, 1'b0);
        do_op("op3_zero",   4'd3,  5'd1,  5'd2,  64'd0,  64'd0, 64'd0, 1'b0);
        do_op("op4_eq",     4'd4,  5'd1,  5'd2,  64'd5,  64'd5, 64'd0, 1'b0);
        do_op("op5_wrap",   4'd5,  5'd1,  5'd2,  64'h1_0000_0000, 64'h1_0000_0000, 64'd0, 1'b0);
        do_op("op6_eq",     4'd6,  5'd1,  5'd2,  64'd0,  64'h1234, 64'h1234, 1'b0);
        do_op("op6_bsel",   4'd6,  5'd1,  5'd31, 64'd0,  64'd5, 64'd0, 1'b1);
        do_op("op7_wrap",   4'd7,  5'd1,  5'd2,  64'd0,  64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
        do_op("op8_nz",     4'd8,  5'd1,  5'd2,  64'd0,  64'd3, 64'd5, 1'b1);
        do_op("op9_bzero",  4'd9,  5'd1,  5'd2,  64'd0,  64'd2, 64'd0, 1'b0);
        do_op("op10_f",     4'd10, 5'd1,  5'd2,  64'd0,  64'd1, 64'd0, 1'b0);
        do_op("op10_t",     4'd10, 5'd1,  5'd2,  64'd0,  64'd0, 64'd0, 1'b1);
        do_op("op11_f",     4'd11, 5'd1,  5'd2,  '1,     64'd0, 64'd0, 1'b0);
        do_op("op12_out",   4'd12, 5'd1,  5'd2,  64'd1,  64'd1, 64'd0, 1'b0);
        do_op("op12_lo6",   4'd12, 5'd1,  5'd2,  64'h40, 64'h8000_0000_0000_0000, 64'd0, 1'b1);
        do_op("op13_f",     4'd13, 5'd1,  5'd2,  64'd4,  64'd1, 64'h10, 1'b0);
        do_op("op14_asel",  4'd14, 5'd25, 5'd2,  64'd0,  64'd3, 64'd0, 1'b1);
        do_op("op14_f",     4'd14, 5'd1,  5'd2,  64'd0,  64'd3, 64'd0, 1'b0);
        do_op("op15_f",     4'd15, 5'd1,  5'd2,  64'd0,  '1, 64'd1, 1'b0);
        do_op("op1_asel",   4'd1,  5'd25, 5'd2,  64'd0,  64'd3, 64'd0, 1'b0);
        cfg_write(5'd7, 4'd0, 5'd0, 5'd0, 64'd0);

        // Backpressure: entry 10+k fails when var(10+k) is zero.
        for (int k = 0; k < 5; k++) cfg_write(5'(10 + k), 4'd1, 5'(10 + k), 5'd0, 64'd0);
        out_ready = 1'b0;
        nacc = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_vars  = bp_cand(nacc);
            acc      = in_ready;
            tick();
            if (acc) nacc++;
        end
        in_valid = 1'b0;
        check("bp_accepted", nacc, 3);
        check("bp_in_ready", in_ready, 0);
        check("bp_hold_valid", out_valid, 1);
        check("bp_hold_idx", out_fail_idx, 10);
        tick();
        check("bp_hold_idx2", out_fail_idx, 10);
        check("bp_hold_sat", out_sat, 0);
        out_ready = 1'b1;
        ngot = 0;
        for (int c = 0; c < 8; c++) begin
            if (out_valid) begin
                check($sformatf("bp_order%0d", ngot), out_fail_idx, 64'(10 + ngot));
                ngot++;
            end
            tick();
        end
        check("bp_count", ngot, 3);

        // Reset with three candidates in flight.
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            in_vars  = bp_cand(c);
            tick();
        end
        in_valid = 1'b0;
        check("mrst_full", out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check("mrst_out_valid", out_valid, 0);
        check("mrst_in_ready", in_ready, 1);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        nseen = 0;
        for (int c = 0; c < 6; c++) begin
            if (out_valid) nseen++;
            tick();
        end
        check("mrst_no_result", nseen, 0);
        check("mrst_total", total_cnt, 0);
        run_one(bp_cand(0), s, idx);
        check("mrst_table_nop_sat", s, 1);
        check("mrst_table_nop_idx", idx, 0);
        tick();

        // 1 result delivered above plus 16 streamed: counters saturate at 15.
        in_valid = 1'b1;
        in_vars  = '0;
        repeat (16) tick();
        in_valid = 1'b0;
        repeat (4) tick();
        check("sat_total", total_cnt, 15);
        check("sat_satcnt", sat_cnt, 15);

        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_valid("clr");
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("clr_total", total_cnt, 0);
        check("clr_satcnt", sat_cnt, 0);
        run_one('0, s, idx);
        tick();
        check("clr_after_total", total_cnt, 1);
        check("clr_after_sat", sat_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
